// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter with round-robin grant and fixed-length access strobes.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (one-cycle completion pulse).
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        stall0,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        winner;

  // On a tie the requester not granted last wins; otherwise the sole requester wins.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          gnt_d   = winner;
          last_d  = winner;
          we_d    = winner ? we1 : we0;
          addr_d  = winner ? addr1 : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          cnt_d   = CntInit;
          state_d = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = we_q ? 32'h0 : mem_read_data;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_read       = (state_q == StAccess) && !we_q;
  assign mem_write      = (state_q == StAccess) && we_q;
  assign mem_address    = (state_q == StAccess) ? addr_q : 32'h0;
  assign mem_write_data = (state_q == StAccess) ? wdata_q : 32'h0;
  assign done0          = (state_q == StDone) && !gnt_q;
  assign done1          = (state_q == StDone) && gnt_q;
  assign rdata          = rdata_q;
  assign stall0         = req0 && !done0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table on a WAIT_CYCLES=2 instance,
// plus sequences for fairness, asynchronous reset and a WAIT_CYCLES=1 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, stall0, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

  logic        rst_n_b, req0_b, req1_b, we0_b, we1_b;
  logic [31:0] addr0_b, addr1_b, wdata0_b, wdata1_b;
  logic        done0_b, done1_b, stall0_b, mem_read_b, mem_write_b;
  logic [31:0] rdata_b, mem_address_b, mem_write_data_b, mem_read_data_b;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .stall0(stall0),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
    .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .done0(done0_b), .done1(done1_b), .rdata(rdata_b), .stall0(stall0_b),
    .mem_address(mem_address_b), .mem_write_data(mem_write_data_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_read_data(mem_read_data_b)
  );

  // Word-addressed data memory model for the main instance.
  logic [31:0] mem [64];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
  assign mem_read_data   = mem[mem_address[7:2]];
  assign mem_read_data_b = mem_address_b ^ 32'hA5A5_0000;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        x_rd, x_wr;
    logic [31:0] x_addr;
    logic        x_dn0, x_dn1;
    logic [31:0] x_rdata;
    logic        x_st0;
  } vec_t;

  function automatic vec_t mk(input int unsigned rst, r0, w0, a0, d0, r1, w1, a1, d1,
                              input int unsigned xrd, xwr, xaddr, xd0, xd1, xrdata, xst);
    vec_t v;
    v.rst = rst[0];   v.r0 = r0[0];   v.w0 = w0[0];   v.a0 = a0;   v.d0 = d0;
    v.r1 = r1[0];     v.w1 = w1[0];   v.a1 = a1;      v.d1 = d1;
    v.x_rd = xrd[0];  v.x_wr = xwr[0]; v.x_addr = xaddr;
    v.x_dn0 = xd0[0]; v.x_dn1 = xd1[0]; v.x_rdata = xrdata; v.x_st0 = xst[0];
    return v;
  endfunction

  localparam int NumVec = 26;
  vec_t vecs [NumVec];

  int gnt [6];
  int tdone [6];
  int n, cyc;
  logic seen;

  initial begin
    //              rst r0 w0 a0    d0    r1 w1 a1    d1     rd wr addr  d0 d1 rdata        st0
    // single load of 0x10
    vecs[0]  = mk(1, 1, 0, 'h10, 0,    0, 0, 0,    0,     1, 0, 'h10, 0, 0, 0,           1);
    vecs[1]  = mk(1, 1, 0, 'h10, 0,    0, 0, 0,    0,     1, 0, 'h10, 0, 0, 0,           1);
    vecs[2]  = mk(1, 1, 0, 'h10, 0,    0, 0, 0,    0,     0, 0, 0,    1, 0, 'hDEADBEEF,  0);
    vecs[3]  = mk(1, 0, 0, 'h10, 0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 'hDEADBEEF,  0);
    // reset, then tied stores: requester 0 first
    vecs[4]  = mk(0, 0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 0,           0);
    vecs[5]  = mk(1, 1, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 1, 'h4,  0, 0, 0,           1);
    vecs[6]  = mk(1, 1, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 1, 'h4,  0, 0, 0,           1);
    vecs[7]  = mk(1, 1, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 0, 0,    1, 0, 0,           0);
    vecs[8]  = mk(1, 0, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 0, 0,    0, 0, 0,           0);
    vecs[9]  = mk(1, 0, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 1, 'h8,  0, 0, 0,           0);
    vecs[10] = mk(1, 0, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 1, 'h8,  0, 0, 0,           0);
    vecs[11] = mk(1, 0, 1, 'h4,  'h11, 1, 1, 'h8,  'h22,  0, 0, 0,    0, 1, 0,           0);
    vecs[12] = mk(1, 0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 0,           0);
    // address change and request drop mid-access
    vecs[13] = mk(1, 1, 0, 'h20, 0,    0, 0, 0,    0,     1, 0, 'h20, 0, 0, 0,           1);
    vecs[14] = mk(1, 0, 0, 'h40, 0,    0, 0, 0,    0,     1, 0, 'h20, 0, 0, 0,           0);
    vecs[15] = mk(1, 0, 0, 'h40, 0,    0, 0, 0,    0,     0, 0, 0,    1, 0, 'h10000008,  0);
    vecs[16] = mk(1, 0, 0, 'h40, 0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 'h10000008,  0);
    // reset during a requester-1 load, then a normal store
    vecs[17] = mk(1, 0, 0, 0,    0,    1, 0, 'h10, 0,     1, 0, 'h10, 0, 0, 'h10000008,  0);
    vecs[18] = mk(1, 0, 0, 0,    0,    1, 0, 'h10, 0,     1, 0, 'h10, 0, 0, 'h10000008,  0);
    vecs[19] = mk(0, 0, 0, 0,    0,    1, 0, 'h10, 0,     0, 0, 0,    0, 0, 0,           0);
    vecs[20] = mk(1, 0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 0,           0);
    vecs[21] = mk(1, 0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 0,           0);
    vecs[22] = mk(1, 0, 0, 0,    0,    1, 1, 'hC,  'h33,  0, 1, 'hC,  0, 0, 0,           0);
    vecs[23] = mk(1, 0, 0, 0,    0,    1, 1, 'hC,  'h33,  0, 1, 'hC,  0, 0, 0,           0);
    vecs[24] = mk(1, 0, 0, 0,    0,    1, 1, 'hC,  'h33,  0, 0, 0,    0, 1, 0,           0);
    vecs[25] = mk(1, 0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0,    0, 0, 0,           0);

    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[4] = 32'hDEAD_BEEF;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_n_b = 1'b0; req0_b = 1'b0; req1_b = 1'b0; we0_b = 1'b0; we1_b = 1'b0;
    addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset mem_read", 32'(mem_read), 32'h0);
    chk("reset mem_write", 32'(mem_write), 32'h0);
    chk("reset done0", 32'(done0), 32'h0);
    chk("reset done1", 32'(done1), 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset stall0", 32'(stall0), 32'h0);

    for (int i = 0; i < NumVec; i++) begin
      rst_n = vecs[i].rst;
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(vecs[i].x_rd));
      chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].x_wr));
      chk($sformatf("v%0d mem_address", i), mem_address, vecs[i].x_addr);
      chk($sformatf("v%0d done0", i), 32'(done0), 32'(vecs[i].x_dn0));
      chk($sformatf("v%0d done1", i), 32'(done1), 32'(vecs[i].x_dn1));
      chk($sformatf("v%0d rdata", i), rdata, vecs[i].x_rdata);
      chk($sformatf("v%0d stall0", i), 32'(stall0), 32'(vecs[i].x_st0));
    end
    chk("store word 0x4", mem[1], 32'h11);
    chk("store word 0x8", mem[2], 32'h22);
    chk("store word 0xC", mem[3], 32'h33);

    // Fairness: both requesters load continuously after a fresh reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    n = 0;
    cyc = 0;
    while (n < 6 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done0 || done1) begin
        gnt[n] = done1 ? 1 : 0;
        tdone[n] = cyc;
        chk($sformatf("fair rdata %0d", n), rdata, done1 ? 32'h22 : 32'hDEAD_BEEF);
        n++;
      end
    end
    chk("fair done count", 32'(n), 32'd6);
    if (n > 0) chk("fair first latency", 32'(tdone[0]), 32'd3);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("fair grant %0d", i), 32'(gnt[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("fair spacing %0d", i), 32'(tdone[i] - tdone[i-1]), 32'd4);
    end

    // Asynchronous reset in the second ACCESS cycle drops strobes without a clock edge.
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(posedge clk);
    #1;
    chk("rst seq access1 mem_read", 32'(mem_read), 32'h1);
    @(posedge clk);
    #1;
    chk("rst seq access2 mem_read", 32'(mem_read), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst seq async mem_read", 32'(mem_read), 32'h0);
    chk("rst seq async mem_address", mem_address, 32'h0);
    req0 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | done0 | done1 | mem_read;
    end
    chk("rst seq no done after release", 32'(seen), 32'h0);

    // WAIT_CYCLES=1: back-to-back requester-1 loads, one access every 3 cycles.
    rst_n_b = 1'b1;
    req1_b = 1'b1; we1_b = 1'b0; addr1_b = 32'h30;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("w1 c%0d mem_read", k), 32'(mem_read_b), 32'((k % 3) == 1));
      chk($sformatf("w1 c%0d done1", k), 32'(done1_b), 32'((k % 3) == 2));
      if ((k % 3) == 2) chk($sformatf("w1 c%0d rdata", k), rdata_b, 32'hA5A5_0030);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of cycles the memory strobes are held per access (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports req0 / req1  input  1  access request from requester 0 (CPU data port) and requester 1 (loader/debug port).
REQ-005 SHALL have ports we0 / we1  input  1  write enable for each requester: 1 = store, 0 = load.
REQ-006 SHALL have ports addr0 / addr1  input  32  byte address for each requester.
REQ-007 SHALL have ports wdata0 / wdata1  input  32  store data for each requester.
REQ-008 SHALL have ports done0 / done1  output  1  one-cycle completion pulse to each requester.
REQ-009 SHALL have port rdata  output  32  load data, valid while done0 or done1 is high.
REQ-010 SHALL have port stall0  output  1  high while req0=1 and done0=0; freezes the CPU PC.
REQ-011 SHALL have ports mem_address / mem_write_data  output  32  address and store data driven to the data memory.
REQ-012 SHALL have ports mem_read / mem_write  output  1  data memory strobes.
REQ-013 SHALL have port mem_read_data  input  32  data returned by the data memory.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 SHALL, in IDLE with any request high, latch the winner's index, we, addr and wdata on the clock edge, load the wait counter with WAIT_CYCLES, and move to ACCESS.
REQ-016 SHALL grant by round-robin on simultaneous requests: the requester not granted last wins; with a single request, that requester wins.
REQ-017 SHALL update the last-grant register only when a grant is issued.
REQ-018 SHALL, in ACCESS, drive mem_address and mem_write_data from the latched values, and assert mem_read (we=0) or mem_write (we=1) for exactly WAIT_CYCLES consecutive cycles; both strobes are never high together.
REQ-019 SHALL decrement the counter each ACCESS cycle; at count 1, capture mem_read_data into rdata on that edge and move to DONE.
REQ-020 SHALL, in DONE, pulse done of the granted requester for exactly one cycle, keep both strobes low, then return to IDLE.
REQ-021 SHALL, in DONE, hold rdata at the value captured for loads; for stores, rdata is 0.
REQ-022 SHALL give request-to-done latency of WAIT_CYCLES+1 cycles after the granting edge, and at most one access per WAIT_CYCLES+2 cycles.
REQ-023 SHALL ignore request inputs outside IDLE; latched addr, data and we are unaffected by input changes mid-access.
REQ-024 SHALL complete an access whose request drops mid-access, including its done pulse.
REQ-025 SHALL keep mem_read, mem_write, done0 and done1 low in IDLE; mem_address and mem_write_data are 0 in IDLE.

Reset
REQ-026 SHALL, on rst_n=0 at any time, immediately force state to IDLE, counter to 0, rdata to 0, strobes and done pulses low, and last-grant to requester 1, so requester 0 wins the first tie.
REQ-027 SHALL abandon an in-flight access on reset mid-ACCESS, with no done pulse issued after rst_n rises.
REQ-028 SHALL begin arbitration on the first rising clk edge with rst_n=1.

Verification
REQ-029 Single load: WAIT_CYCLES=2; req0=1, we0=0, addr0=0x10, memory[0x10]=0xDEADBEEF -> mem_read high 2 cycles with mem_address=0x10; done0 pulses 3 cycles after grant edge with rdata=0xDEADBEEF; stall0 high until then.
REQ-030 Tie after reset: req0=req1=1, both stores (0x4 <- 0x11, 0x8 <- 0x22) -> requester 0 is served first and requester 1 next; the memory holds 0x11 at 0x4 and 0x22 at 0x8; done0 precedes done1 by WAIT_CYCLES+2 cycles.
REQ-031 Fairness: req0 and req1 held high for 6 accesses -> grants alternate 0,1,0,1,0,1.
REQ-032 Mid-access change: addr0 changes from 0x20 to 0x40 and req0 drops during ACCESS -> mem_address stays 0x20 and done0 still pulses once.
REQ-033 Reset mid-operation: rst_n=0 in the second ACCESS cycle -> strobes drop the same cycle, no done pulse, and the next request after release is granted normally.
REQ-034 WAIT_CYCLES=1: back-to-back req1 loads -> mem_read is high 1 cycle per access, and done1 pulses every 3 cycles.
